// File: rtl/coriolis_mul_arbiter_pkg.sv
// Shared constants and helpers for the round-robin multiply arbiter and its tag FIFO.
package coriolis_mul_arbiter_pkg;

  localparam int STREAMW_DEF = 32;
  localparam int NREQ_DEF    = 2;

  // Ceiling log2 with a floor of 1, so a 2-entry space still gets a 1-bit index.
  function automatic int clog2(input int v);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  localparam int TAGW_DEF = clog2(NREQ_DEF);

endpackage

// File: rtl/coriolis_tag_fifo.sv
// In-order requester-tag FIFO; the head entry is readable combinationally.
module coriolis_tag_fifo
  import coriolis_mul_arbiter_pkg::*;
#(
  parameter int TAGW  = 1,
  parameter int DEPTH = 4,
  localparam int PW   = clog2(DEPTH),
  localparam int CW   = clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [TAGW-1:0] din,
  output logic [TAGW-1:0] dout,
  output logic            full,
  output logic            empty,
  output logic [CW-1:0]   count
);

  logic [TAGW-1:0] mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push_ok, pop_ok;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    push_ok  = push & ~full;
    pop_ok   = pop & ~empty;
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/coriolis_mul_arbiter.sv
// Round-robin sharing of one in-order pipelined unit among NREQ requesters, with tag-steered returns.
module coriolis_mul_arbiter
  import coriolis_mul_arbiter_pkg::*;
#(
  parameter int STREAMW = STREAMW_DEF,
  parameter int NREQ    = NREQ_DEF,
  parameter int TAGW    = TAGW_DEF,
  parameter int DEPTH   = 4,
  localparam int CW     = clog2(DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_ivalid,
  input  logic [NREQ*STREAMW-1:0] req_in1,
  input  logic [NREQ*STREAMW-1:0] req_in2,
  output logic [NREQ-1:0]         req_iready,
  output logic [NREQ-1:0]         rsp_ovalid,
  output logic [STREAMW-1:0]      rsp_out,
  input  logic [NREQ-1:0]         rsp_oready,
  output logic                    m_ivalid,
  output logic [STREAMW-1:0]      m_in1,
  output logic [STREAMW-1:0]      m_in2,
  input  logic                    m_iready,
  input  logic                    m_ovalid,
  input  logic [STREAMW-1:0]      m_out,
  output logic                    m_oready,
  output logic                    busy,
  output logic                    err
);

  logic [TAGW-1:0] rr_ptr_q, rr_ptr_d;
  logic            err_q, err_d;
  logic [TAGW-1:0] g, head;
  logic [TAGW:0]   cand;
  logic            found, grant, has_tag, pop;
  logic            fifo_full, fifo_empty;
  logic [CW-1:0]   fifo_count;

  // Scan from rr_ptr for the first valid requester; the wrap is a single subtract.
  always_comb begin
    found = 1'b0;
    g     = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (TAGW+1)'(k);
      if (cand >= (TAGW+1)'(NREQ)) cand = cand - (TAGW+1)'(NREQ);
      if (!found && req_ivalid[cand[TAGW-1:0]]) begin
        found = 1'b1;
        g     = cand[TAGW-1:0];
      end
    end
  end

  always_comb begin
    grant      = found & m_iready & ~fifo_full & ~rst;
    req_iready = '0;
    m_in1      = '0;
    m_in2      = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant && g == TAGW'(i)) begin
        req_iready[i] = 1'b1;
        m_in1         = req_in1[i*STREAMW +: STREAMW];
        m_in2         = req_in2[i*STREAMW +: STREAMW];
      end
    end
    m_ivalid = grant;
    rr_ptr_d = rr_ptr_q;
    if (grant) rr_ptr_d = (g == TAGW'(NREQ-1)) ? '0 : g + 1'b1;
  end

  always_comb begin
    has_tag    = ~fifo_empty & ~rst;
    rsp_ovalid = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (head == TAGW'(i)) rsp_ovalid[i] = m_ovalid & has_tag;
    end
    m_oready = rsp_oready[head] & has_tag;
    pop      = m_ovalid & m_oready;
    // A result with nothing in flight means the unit and the tag stream have diverged.
    err_d    = err_q | (m_ovalid & fifo_empty);
  end

  assign rsp_out = m_out;
  assign busy    = (fifo_count != '0) & ~rst;
  assign err     = err_q & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      err_q    <= err_d;
    end
  end

  coriolis_tag_fifo #(
    .TAGW  (TAGW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (grant),
    .pop   (pop),
    .din   (g),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_coriolis_mul_arbiter.sv
// Scoreboard bench: 2 requesters sharing a latency-1 in-order multiply stub.
module tb_coriolis_mul_arbiter;

  localparam int W = 32;
  localparam int N = 2;
  localparam int D = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_ivalid = '0;
  logic [N*W-1:0] req_in1 = '0;
  logic [N*W-1:0] req_in2 = '0;
  logic [N-1:0]   req_iready;
  logic [N-1:0]   rsp_ovalid;
  logic [W-1:0]   rsp_out;
  logic [N-1:0]   rsp_oready = '1;
  logic           m_ivalid;
  logic [W-1:0]   m_in1, m_in2;
  logic           m_iready = 1'b1;
  logic           m_ovalid;
  logic [W-1:0]   m_out;
  logic           m_oready;
  logic           busy, err;

  logic           inj_err = 1'b0;
  logic           stub_ov_q = 1'b0;
  logic [W-1:0]   stub_out_q = '0;
  logic           stub_acc, stub_pop;
  logic [W-1:0]   stub_prod;
  logic [W-1:0]   uq[$];

  int           exp_id[$];
  logic [W-1:0] exp_dat[$];
  int           got_id[$];
  logic [W-1:0] got_dat[$];
  int           gq[$];

  int total = 0;
  int bad = 0;

  coriolis_mul_arbiter #(.STREAMW(W), .NREQ(N), .TAGW(1), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .req_ivalid(req_ivalid), .req_in1(req_in1), .req_in2(req_in2), .req_iready(req_iready),
    .rsp_ovalid(rsp_ovalid), .rsp_out(rsp_out), .rsp_oready(rsp_oready),
    .m_ivalid(m_ivalid), .m_in1(m_in1), .m_in2(m_in2), .m_iready(m_iready),
    .m_ovalid(m_ovalid), .m_out(m_out), .m_oready(m_oready),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  assign m_ovalid = stub_ov_q | inj_err;
  assign m_out    = stub_out_q;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, want, $time);
    end
  endtask

  // Stub: handshakes sampled mid-cycle, committed at the edge; results visible one cycle later.
  always @(negedge clk) begin
    stub_acc  = m_ivalid && m_iready;
    stub_prod = m_in1 * m_in2;
    stub_pop  = m_ovalid && m_oready;
  end

  always @(posedge clk) begin
    if (rst) uq.delete();
    else begin
      if (stub_pop && uq.size() > 0) void'(uq.pop_front());
      if (stub_acc) uq.push_back(stub_prod);
    end
    stub_ov_q  <= (uq.size() != 0);
    stub_out_q <= (uq.size() != 0) ? uq[0] : '0;
  end

  always @(negedge clk) begin
    if (rst) begin
      exp_id.delete();
      exp_dat.delete();
    end else begin
      for (int i = 0; i < N; i++) begin
        if (rsp_ovalid[i] && rsp_oready[i]) begin
          $display("rsp  req%0d data=%0h", i, rsp_out);
          got_id.push_back(i);
          got_dat.push_back(rsp_out);
          if (exp_id.size() == 0) chk("rsp_extra", 1, 0);
          else begin
            chk("rsp_id", i, exp_id.pop_front());
            chk("rsp_data", rsp_out, exp_dat.pop_front());
          end
        end
      end
      for (int i = 0; i < N; i++) begin
        if (req_ivalid[i] && req_iready[i]) begin
          $display("issue req%0d a=%0h b=%0h", i, req_in1[i*W +: W], req_in2[i*W +: W]);
          exp_id.push_back(i);
          exp_dat.push_back(req_in1[i*W +: W] * req_in2[i*W +: W]);
          gq.push_back(i);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200 && busy; i++) cyc();
    chk(tag, busy, 0);
  endtask

  task automatic send(input int r, input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n = 0;
    req_ivalid[r] = 1'b1;
    req_in1[r*W +: W] = a;
    req_in2[r*W +: W] = b;
    @(negedge clk);
    while (!req_iready[r] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_ack", req_iready[r], 1);
    cyc();
    req_ivalid[r] = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_iready", req_iready, 0);
    chk("rst_ovalid", rsp_ovalid, 0);
    chk("rst_m_ivalid", m_ivalid, 0);
    chk("rst_m_oready", m_oready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    cyc(); cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rr_ptr", dut.rr_ptr_q, 0);
    chk("rst_count", dut.u_fifo.count, 0);
    cyc();

    // Single requester stream
    got_id.delete(); got_dat.delete();
    send(0, 32'd3, 32'hFFFF_FFFF);
    send(0, 32'd5, 32'hFFFF_FFFF);
    send(0, 32'd7, 32'hFFFF_FFFF);
    wait_idle("t1_idle");
    cyc();
    chk("t1_nrsp", got_dat.size(), 3);
    if (got_dat.size() == 3) begin
      chk("t1_r0", got_dat[0], 32'hFFFF_FFFD);
      chk("t1_r1", got_dat[1], 32'hFFFF_FFFB);
      chk("t1_r2", got_dat[2], 32'hFFFF_FFF9);
      for (int k = 0; k < 3; k++) chk("t1_id", got_id[k], 0);
    end
    chk("t1_rr_ptr", dut.rr_ptr_q, 1);

    // Both requesters valid continuously
    pulse_reset();
    gq.delete(); got_id.delete(); got_dat.delete();
    req_in1 = {32'd10, 32'd2};
    req_in2 = {32'd4, 32'd4};
    req_ivalid = 2'b11;
    repeat (8) cyc();
    req_ivalid = 2'b00;
    wait_idle("t2_idle");
    cyc();
    chk("t2_issues", gq.size(), 8);
    chk("t2_nrsp", got_dat.size(), 8);
    if (gq.size() == 8 && got_dat.size() == 8) begin
      for (int k = 0; k < 8; k++) begin
        chk("t2_grant", gq[k], k % 2);
        chk("t2_rid", got_id[k], k % 2);
        chk("t2_rdat", got_dat[k], (k % 2) ? 32'd40 : 32'd8);
      end
    end

    // Backpressure on req1 until full, then the full/pop boundary
    rsp_oready = 2'b01;
    req_in1[W +: W] = 32'd6;
    req_in2[W +: W] = 32'd7;
    req_ivalid = 2'b10;
    repeat (8) cyc();
    @(negedge clk);
    chk("bp_count", dut.u_fifo.count, D);
    chk("bp_m_oready", m_oready, 0);
    chk("bp_iready", req_iready, 0);
    chk("bp_busy", busy, 1);
    cyc();
    rsp_oready = 2'b11;
    @(negedge clk);
    chk("full_pop_oready", m_oready, 1);
    chk("full_pop_noissue", req_iready, 0);
    cyc();
    @(negedge clk);
    chk("full_next_count", dut.u_fifo.count, 3);
    chk("full_next_issue", req_iready, 2'b10);
    cyc();
    req_ivalid = 2'b00;
    wait_idle("bp_idle");
    chk("bp_drained", dut.u_fifo.count, 0);

    // Result with nothing in flight
    cyc();
    inj_err = 1'b1;
    @(negedge clk);
    chk("err_ovalid", rsp_ovalid, 0);
    chk("err_oready", m_oready, 0);
    cyc();
    inj_err = 1'b0;
    @(negedge clk);
    chk("err_set", err, 1);
    repeat (3) cyc();
    @(negedge clk);
    chk("err_sticky", err, 1);
    cyc();
    rst = 1'b1;
    cyc();
    @(negedge clk);
    chk("err_cleared", err, 0);
    cyc();
    rst = 1'b0;
    cyc();

    // Reset with three operations in flight
    rsp_oready = 2'b10;
    req_in1[0 +: W] = 32'd1;
    req_in2[0 +: W] = 32'd1;
    req_ivalid = 2'b01;
    repeat (3) cyc();
    req_ivalid = 2'b00;
    @(negedge clk);
    chk("mid_count3", dut.u_fifo.count, 3);
    chk("mid_busy1", busy, 1);
    cyc();
    rst = 1'b1;
    cyc();
    @(negedge clk);
    chk("mid_count0", dut.u_fifo.count, 0);
    chk("mid_busy0", busy, 0);
    chk("mid_rr_ptr", dut.rr_ptr_q, 0);
    chk("mid_m_ivalid", m_ivalid, 0);
    chk("mid_m_oready", m_oready, 0);
    chk("mid_ovalid", rsp_ovalid, 0);
    chk("mid_iready", req_iready, 0);
    cyc();
    rst = 1'b0;
    rsp_oready = 2'b11;
    repeat (4) cyc();
    chk("mid_no_stale", m_ovalid, 0);
    chk("sb_empty", exp_id.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/coriolis_mul_arbiter.md
Name: coriolis_mul_arbiter

Overview:
- Round-robin arbiter that shares one pipelined leaf map node (e.g. a multiply unit) between NREQ independent requester streams.
- Sits between the kernel's producer streams and a single shared compute instance.
- Issues one operand pair per cycle to the shared unit and records the requester ID in an in-order tag FIFO.
- Steers each result back to the requester that issued it, using the same ivalid/iready/ovalid/oready handshake as the leaf nodes.

Parameters:
- STREAMW, 32, data width of operands and results.
- NREQ, 2, number of requesters (2..8).
- TAGW, 1, requester tag width; must equal clog2(NREQ), and is 1 when NREQ=2.
- DEPTH, 4, tag FIFO depth, i.e. maximum operations in flight inside the shared unit (power of 2, 2..16).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_ivalid  in  NREQ  per-requester operand valid
- req_in1  in  NREQ*STREAMW  packed operand 1; requester i occupies bits [i*STREAMW +: STREAMW]
- req_in2  in  NREQ*STREAMW  packed operand 2; same packing
- req_iready  out  NREQ  per-requester accept (one-hot or zero)
- rsp_ovalid  out  NREQ  per-requester result valid (one-hot or zero)
- rsp_out  out  STREAMW  result, broadcast to all requesters
- rsp_oready  in  NREQ  per-requester result ready
- m_ivalid  out  1  operand valid to shared unit
- m_in1, m_in2  out  STREAMW  operands to shared unit
- m_iready  in  1  shared unit ready
- m_ovalid  in  1  shared unit result valid
- m_out  in  STREAMW  shared unit result
- m_oready  out  1  ready to shared unit
- busy  out  1  tag FIFO non-empty
- err  out  1  sticky protocol error

Behaviour:
- Clocking and reset: single clock, clk. Reset rst is synchronous and active-high.
- Reset state:
  - rr_ptr = 0; tag FIFO empty (count = 0); err = 0.
  - All outputs 0 while rst is high: req_iready, rsp_ovalid, m_ivalid, m_oready, busy, err.
- Handshake: a transfer occurs in a cycle where valid and ready are both 1. No valid may depend combinationally on its own ready.
- Issue condition: can_issue = m_iready & (count != DEPTH). Full blocks issue even if a pop occurs in the same cycle.
- Grant:
  - g is the first requester i, scanning rr_ptr, rr_ptr+1, … modulo NREQ, with req_ivalid[i]=1.
  - Grant is valid only when can_issue and at least one req_ivalid is set.
- Issue outputs (combinational, same cycle):
  - req_iready[g] = 1; all other req_iready = 0.
  - m_ivalid = 1; m_in1 and m_in2 take the slices of requester g.
  - If there is no grant: m_ivalid = 0 and m_in1/m_in2 are held at 0.
- Issue update: on a granted issue, push g into the tag FIFO and set rr_ptr <= (g+1) mod NREQ. Otherwise rr_ptr holds.
- Return path (h = tag at FIFO head):
  - rsp_ovalid[h] = m_ovalid & (count != 0); all other rsp_ovalid = 0.
  - m_oready = rsp_oready[h] & (count != 0).
  - rsp_out = m_out, unregistered.
  - Pop on m_ovalid & m_oready.
- Ordering: the shared unit is in-order, so results map to tags in FIFO order.
- Backpressure: while rsp_oready[h] = 0, m_oready = 0 and the shared unit stalls. Other requesters can still issue until the FIFO fills.
- Simultaneous push and pop: count is unchanged. Head and tail pointers both advance and wrap modulo DEPTH.
- Error: m_ovalid = 1 while count == 0 sets err = 1. err clears only on rst. No pop occurs in that cycle.
- busy = (count != 0), registered from count.
- Reset mid-operation: in-flight tags are discarded. The shared unit must be reset by the same rst.
- Latency: issue path 0 cycles (combinational); return path 0 cycles. End-to-end latency equals the shared unit's latency.

Decomposition:
- Shared include/package: STREAMW default, the clog2 helper function, and the NREQ-to-TAGW derivation constant.
- One natural sub-module, coriolis_tag_fifo:
  - synchronous FIFO, TAGW wide, DEPTH deep, count register;
  - ports: push, pop, din, dout, full, empty, count;
  - shares the same clk and rst.
- Round-robin grant logic and return steering stay in the top module.

Test Plan:
- Single requester, stub unit (latency 1, multiply):
  - Stimulus: NREQ=2, req0 streams in1 = 3,5,7 with in2 = -1; req1 idle.
  - Required: rsp_ovalid[0] with rsp_out = -3,-5,-7 in order; rsp_ovalid[1] never asserts; rr_ptr ends at 1.
- Both requesters valid continuously (req0 in1=2, req1 in1=10, in2=4):
  - Grants alternate 0,1,0,1.
  - rsp_out = 8 to req0 and 40 to req1, alternating.
  - One issue per cycle.
- Backpressure:
  - Stimulus: rsp_oready[1]=0 with req1 results pending.
  - Required: m_oready=0 and the unit stalls; issues continue until count=DEPTH=4; req_iready stays 0 while full.
  - Release rsp_oready[1]=1: drains in order; count returns to 0.
- Full boundary: with count=4, pop and a pending request in the same cycle -> no issue that cycle; issue occurs the next cycle.
- Error: inject m_ovalid=1 with the FIFO empty -> err=1 and stays 1; rsp_ovalid=0; rst clears err.
- Reset mid-stream: assert rst with count=3 -> the next cycle shows count=0, busy=0, all valids/readys 0, rr_ptr=0.
